menu_key_decoder: RTL and testbench
===================================

# menu_key_decoder

Converts the raw PS/2 keyboard lines of the Basys3 USB-HID bridge into the single-cycle, one-hot `keyboard_out[2:0]` key strobes consumed by the menu and in-game logic. It is the producer side of the 3-bit key bus: bit 2 = up, bit 1 = down, bit 0 = enter/select. Each physical key press yields exactly one strobe, regardless of how long the key is held or how often it auto-repeats. It sits between the board PS/2 pins and the menu FSM, in the `clk` domain.

## Interface
- `TIMEOUT_CYCLES`, 6500, `clk` cycles without a PS/2 falling edge before a partial frame is discarded (100 µs at 65 MHz).
- `clk`, input, 1, system clock; all logic is on the rising edge.
- `rst`, input, 1, asynchronous, active-low reset.
- `ps2_clk`, input, 1, raw PS/2 clock from the pin; asynchronous.
- `ps2_data`, input, 1, raw PS/2 data from the pin; asynchronous.
- `keyboard_out`, output, 3, one-cycle key strobes: [2] up, [1] down, [0] enter; at most one bit high.
- `key_held`, output, 3, level outputs: key currently pressed, same bit map.
- `frame_error`, output, 1, one-cycle pulse on a parity, start or stop error, or on a timeout.

## Operation
- **Input synchroniser.** `ps2_clk` and `ps2_data` pass through 2-FF synchronisers. A falling edge is detected on the synchronised `ps2_clk`. Data is sampled in the same cycle the edge is detected.
- **Frame receiver.** Each frame has 11 bits:
  - a start bit (must be 0);
  - 8 data bits, LSB first;
  - an odd-parity bit;
  - a stop bit (must be 1).
- **Frame counter.** A 4-bit counter runs 0..10. It wraps to 0 after the stop bit or after any error.
- **Good frame.** A one-cycle internal `byte_valid` is produced with the 8-bit code.
- **Bad frame.** No `byte_valid` is produced, `frame_error` pulses, and the counter returns to 0.
- **Timeout.** A timeout counter restarts on every falling edge. If it reaches `TIMEOUT_CYCLES` while the frame counter is non-zero, the partial frame is discarded, `frame_error` pulses, and the counter returns to 0. The timeout counter saturates and does not wrap.
- **Key map.**
  - Up: E0 75 (arrow) or 1D (W).
  - Down: E0 72 (arrow) or 1B (S).
  - Enter: 5A (Enter) or 29 (Space).
  - All other codes are ignored.
- **Decoder FSM.** It advances only on `byte_valid`.
  - IDLE: E0→EXT; F0→BRK; a mapped code → make(key); else stay in IDLE.
  - EXT: F0→EXT_BRK; 75/72 → make(up/down); anything else → IDLE.
  - BRK: a mapped non-extended code → break(key); in all cases → IDLE.
  - EXT_BRK: 75/72 → break(up/down); in all cases → IDLE.
  - Any `frame_error` forces the FSM to IDLE, dropping any pending prefix.
- **Make and break.**
  - make(k): if `key_held[k]` = 0, set it and pulse `keyboard_out[k]` for one cycle. If it is already 1 (typematic repeat), no pulse is produced.
  - break(k): clear `key_held[k]`; no pulse.
- **Shared aliases.** W and arrow-up share one bit, and so on. A make from either alias while the bit is held produces no pulse. A break from either alias clears the bit.
- **One-hot guarantee.** One byte completes per strobe, so `keyboard_out` is one-hot or zero by construction. The same holds for any two keys pressed at once.

## Timing
- **Reset.** While `rst` = 0, and immediately on its assertion:
  - `keyboard_out` = 000, `key_held` = 000, `frame_error` = 0;
  - the FSM is in IDLE and all counters are 0.
- **Reset mid-frame.** The partial frame is lost. Reception resumes at the next start bit after release.
- **Detection delay.** A falling edge is detected 2–3 cycles after the pin edge.
- **Stop bit.** If the 11th falling edge is detected in cycle N, then:
  - `byte_valid` is high in cycle N+1;
  - `keyboard_out` (or `frame_error` for a parity or stop error) is high in cycle N+2, for exactly one cycle.
- **Start-bit error.** A start bit of 1 raises `frame_error` at N+1 after the first edge, and the counter stays at 0.
- **Timeout.** `frame_error` is high in the cycle after the timeout counter reaches `TIMEOUT_CYCLES`.
- **Steady state.** There are no back-to-back strobes: PS/2 byte spacing is far longer than a few cycles.

## Structure
- Shared package/header `menu_keys_pkg` holds:
  - the key bit indices `KEY_UP`=2, `KEY_DOWN`=1, `KEY_ENTER`=0;
  - the scancode constants (E0, F0, 75, 72, 1D, 1B, 5A, 29).
  
  The menu FSM uses the same bit indices.
- Sub-module `ps2_rx` contains the synchroniser, frame counter, parity check and timeout. It outputs `byte_valid`, the 8-bit code and `frame_error`.
- The top level holds the decoder FSM and the held/strobe registers.

## Test plan
- **Single key.** Frame 5A, then frames F0 5A → one `keyboard_out`=001 pulse at N+2 after the first frame's stop edge; `key_held[0]` goes 1 then 0; no other pulses.
- **Extended key with repeat.** Frames E0 75, E0 75, E0 75, E0 F0 75 → exactly one 100 pulse; `key_held[2]` stays 1 until the final frame.
- **Parity error.** Frame 1D with wrong parity → `frame_error` pulses once, no strobe, `key_held` = 000. Next, a good 1D → a 100 pulse.
- **Timeout and prefix drop.** Send E0, then 5 bits of a frame, then idle for more than 6500 cycles → `frame_error` once. Then a good frame 72 → no strobe (the E0 prefix is dropped by the error); then a good 1B → a 010 pulse.
- **Aliases.** 1D (up pressed via W) then E0 75 → a single 100 pulse; E0 F0 75 → `key_held[2]` = 0.
- **Reset mid-frame.** Assert `rst`=0 after 6 bits of a frame → all outputs 0 immediately. After release, a full 29 frame → a 001 pulse.

Source files
------------

// File: rtl/menu_keys_pkg.sv
// Shared key-bus bit indices, PS/2 scancodes and decoder state type for the
// menu key path; the menu FSM uses the same KEY_* indices.
package menu_keys_pkg;

  localparam int NUM_KEYS  = 3;
  localparam int KEY_UP    = 2;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_ENTER = 0;

  localparam logic [7:0] SC_EXT        = 8'hE0;
  localparam logic [7:0] SC_BRK        = 8'hF0;
  localparam logic [7:0] SC_ARROW_UP   = 8'h75;
  localparam logic [7:0] SC_ARROW_DOWN = 8'h72;
  localparam logic [7:0] SC_W          = 8'h1D;
  localparam logic [7:0] SC_S          = 8'h1B;
  localparam logic [7:0] SC_ENTER      = 8'h5A;
  localparam logic [7:0] SC_SPACE      = 8'h29;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  // Non-prefixed codes that map onto the key bus; zero vector when unmapped.
  function automatic logic [NUM_KEYS-1:0] plain_key_vec(input logic [7:0] code);
    logic [NUM_KEYS-1:0] v;
    v = '0;
    case (code)
      SC_W:     v[KEY_UP]    = 1'b1;
      SC_S:     v[KEY_DOWN]  = 1'b1;
      SC_ENTER: v[KEY_ENTER] = 1'b1;
      SC_SPACE: v[KEY_ENTER] = 1'b1;
      default:  v = '0;
    endcase
    return v;
  endfunction

  // Codes that follow an E0 prefix (arrow keys).
  function automatic logic [NUM_KEYS-1:0] ext_key_vec(input logic [7:0] code);
    logic [NUM_KEYS-1:0] v;
    v = '0;
    case (code)
      SC_ARROW_UP:   v[KEY_UP]   = 1'b1;
      SC_ARROW_DOWN: v[KEY_DOWN] = 1'b1;
      default:       v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/menu_key_decoder_ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, 11-bit frame counter, odd-parity
// and framing checks, and an inter-edge timeout that discards partial frames.
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 6500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] code,
  output logic       frame_error
);

  localparam int              TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]      LAST_BIT = 4'd10;

  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             clk_prev;
  logic             fall_p0;
  logic             bit_p0;

  logic [3:0]       bit_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout;

  logic [8:0]       shift_p1;
  logic             stop_p1;
  logic             done_p1;
  logic             frame_ok_p1;

  // Stage p0: two-flop synchronisers and falling-edge detect on ps2_clk.
  // Lines idle high, so the synchronisers reset high to avoid a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall_p0 = clk_prev & ~clk_sync[1];
  assign bit_p0  = data_sync[1];
  assign timeout = (tmo_cnt == TMO_MAX) && (bit_cnt != 4'd0);

  // Stage p1: frame counter, timeout and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt     <= 4'd0;
      tmo_cnt     <= '0;
      done_p1     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      done_p1     <= 1'b0;
      frame_error <= 1'b0;
      if (fall_p0) begin
        tmo_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          if (bit_p0) frame_error <= 1'b1;
          else        bit_cnt     <= 4'd1;
        end else if (bit_cnt == LAST_BIT) begin
          bit_cnt <= 4'd0;
          done_p1 <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
        if (timeout) begin
          bit_cnt     <= 4'd0;
          frame_error <= 1'b1;
        end
      end
      if (done_p1 && !frame_ok_p1) frame_error <= 1'b1;
    end
  end

  // Data bits and parity shift in LSB first; qualified by done_p1 only.
  always_ff @(posedge clk) begin
    if (fall_p0 && (bit_cnt != 4'd0) && (bit_cnt != LAST_BIT))
      shift_p1 <= {bit_p0, shift_p1[8:1]};
    if (fall_p0 && (bit_cnt == LAST_BIT))
      stop_p1 <= bit_p0;
  end

  assign frame_ok_p1 = (^shift_p1) & stop_p1;
  assign byte_valid  = done_p1 & frame_ok_p1;
  assign code        = shift_p1[7:0];

endmodule

// File: rtl/menu_key_decoder.sv
// PS/2 keyboard to one-hot menu key strobes: prefix-tracking decoder FSM with
// per-key held state so each press yields exactly one strobe.
module menu_key_decoder
  import menu_keys_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 6500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [NUM_KEYS-1:0] keyboard_out,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                frame_error
);

  logic                byte_valid;
  logic [7:0]          code;
  dec_state_t          state_q;
  dec_state_t          state_d;
  logic [NUM_KEYS-1:0] make_vec;
  logic [NUM_KEYS-1:0] break_vec;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .code       (code),
    .frame_error(frame_error)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Any receive error drops a pending E0/F0 prefix.
  always_comb begin
    state_d = state_q;
    if (frame_error) begin
      state_d = ST_IDLE;
    end else if (byte_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (code == SC_EXT)      state_d = ST_EXT;
          else if (code == SC_BRK) state_d = ST_BRK;
          else                     state_d = ST_IDLE;
        end
        ST_EXT:  state_d = (code == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Prefix codes map to the zero vector, so no explicit exclusion is needed.
  always_comb begin
    make_vec  = '0;
    break_vec = '0;
    if (byte_valid && !frame_error) begin
      case (state_q)
        ST_IDLE:    make_vec  = plain_key_vec(code);
        ST_EXT:     make_vec  = ext_key_vec(code);
        ST_BRK:     break_vec = plain_key_vec(code);
        ST_EXT_BRK: break_vec = ext_key_vec(code);
        default: begin
          make_vec  = '0;
          break_vec = '0;
        end
      endcase
    end
  end

  // Strobe only on the first make; typematic repeats and aliases stay silent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keyboard_out <= '0;
      key_held     <= '0;
    end else begin
      keyboard_out <= make_vec & ~key_held;
      key_held     <= (key_held | make_vec) & ~break_vec;
    end
  end

endmodule

// File: tb/tb_menu_key_decoder.sv
// Randomised and directed PS/2 frame bench for menu_key_decoder with a
// cycle-scheduled behavioural model of strobes, held keys and frame errors.
module tb_menu_key_decoder;

  localparam int T    = 6500;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [2:0] keyboard_out;
  logic [2:0] key_held;
  logic       frame_error;

  menu_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .keyboard_out(keyboard_out),
    .key_held    (key_held),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0, n_pulse = 0, n_err = 0, n_tmo = 0;

  // Model: expected outputs keyed by the cycle in which they must appear.
  logic [2:0] kbd_q [int];
  logic [2:0] held_q[int];
  bit         err_q [int];
  logic [2:0] m_held = 3'b000;
  bit         m_ext = 0, m_brk = 0;
  logic [2:0] cur_held = 3'b000;

  logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h1D, 8'h1B, 8'h5A, 8'h29, 8'h75, 8'hE0};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cur_held = 3'b000;
      chk("reset_kbd", {29'd0, keyboard_out}, 32'd0);
      chk("reset_held", {29'd0, key_held}, 32'd0);
      chk("reset_err", {31'd0, frame_error}, 32'd0);
    end else begin
      if (held_q.exists(cyc)) cur_held = held_q[cyc];
      chk("kbd", {29'd0, keyboard_out}, {29'd0, kbd_q.exists(cyc) ? kbd_q[cyc] : 3'b000});
      chk("held", {29'd0, key_held}, {29'd0, cur_held});
      chk("err", {31'd0, frame_error}, {31'd0, err_q.exists(cyc) ? err_q[cyc] : 1'b0});
      if (keyboard_out != 3'b000) n_pulse++;
      if (frame_error) n_err++;
    end
  end

  function automatic int plain_key(input logic [7:0] c);
    case (c)
      8'h1D:        return 2;
      8'h1B:        return 1;
      8'h5A, 8'h29: return 0;
      default:      return -1;
    endcase
  endfunction

  function automatic int ext_key(input logic [7:0] c);
    case (c)
      8'h75:   return 2;
      8'h72:   return 1;
      default: return -1;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] c, input int at);
    int k;
    logic [2:0] pulse;
    pulse = 3'b000;
    k = -1;
    if (m_brk) begin
      k = m_ext ? ext_key(c) : plain_key(c);
      if (k >= 0) m_held[k] = 1'b0;
      m_ext = 0; m_brk = 0;
    end else if (m_ext) begin
      if (c == 8'hF0) m_brk = 1;
      else begin
        k = ext_key(c);
        m_ext = 0;
        if (k >= 0) begin
          if (!m_held[k]) pulse[k] = 1'b1;
          m_held[k] = 1'b1;
        end
      end
    end else if (c == 8'hE0) m_ext = 1;
    else if (c == 8'hF0) m_brk = 1;
    else begin
      k = plain_key(c);
      if (k >= 0) begin
        if (!m_held[k]) pulse[k] = 1'b1;
        m_held[k] = 1'b1;
      end
    end
    if (pulse != 3'b000) kbd_q[at] = pulse;
    held_q[at] = m_held;
  endtask

  task automatic sched_err(input int at);
    err_q[at] = 1'b1;
    m_ext = 0;
    m_brk = 0;
  endtask

  function automatic logic frame_bit(input logic [7:0] c, input int i, input bit bp, input bit bs);
    if (i == 0) return 1'b0;
    if (i <= 8) return c[i-1];
    if (i == 9) return ~(^c) ^ bp;
    return ~bs;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_fall(input logic b, output int c0);
    ps2_data = b;
    idle(HALF);
    ps2_clk = 1'b0;
    c0 = cyc;
  endtask

  task automatic ps2_rise();
    idle(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input bit bp, input bit bs);
    int c0;
    for (int i = 0; i < 10; i++) begin
      ps2_fall(frame_bit(c, i, bp, bs), c0);
      ps2_rise();
    end
    ps2_fall(frame_bit(c, 10, bp, bs), c0);
    if (bp || bs) sched_err(c0 + 4);
    else          model_byte(c, c0 + 4);
    ps2_rise();
    ps2_data = 1'b1;
    idle(6 + $urandom_range(0, 20));
  endtask

  task automatic send_partial(input logic [7:0] c, input int nbits);
    int c0;
    for (int i = 0; i < nbits - 1; i++) begin
      ps2_fall(frame_bit(c, i, 0, 0), c0);
      ps2_rise();
    end
    ps2_fall(frame_bit(c, nbits - 1, 0, 0), c0);
    sched_err(c0 + T + 4);
    ps2_rise();
    ps2_data = 1'b1;
    idle(T + 20);
  endtask

  task automatic send_start_err();
    int c0;
    ps2_fall(1'b1, c0);
    sched_err(c0 + 3);
    ps2_rise();
    idle(10);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, e0, c0, r;
    idle(5);
    rst = 1'b1;
    idle(5);

    // Single key press and release.
    p0 = n_pulse;
    send_frame(8'h5A, 0, 0);
    chk("t1_held_make", {29'd0, key_held}, 32'h1);
    chk("t1_pulse_make", n_pulse - p0, 1);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h5A, 0, 0);
    chk("t1_held_break", {29'd0, key_held}, 32'h0);
    chk("t1_pulse_total", n_pulse - p0, 1);

    // Extended up arrow with typematic repeat.
    p0 = n_pulse;
    repeat (3) begin
      send_frame(8'hE0, 0, 0);
      send_frame(8'h75, 0, 0);
    end
    chk("t2_held_repeat", {29'd0, key_held}, 32'h4);
    chk("t2_pulse_repeat", n_pulse - p0, 1);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    chk("t2_held_break", {29'd0, key_held}, 32'h0);

    // Parity error, then a good frame.
    p0 = n_pulse; e0 = n_err;
    send_frame(8'h1D, 1, 0);
    chk("t3_err_count", n_err - e0, 1);
    chk("t3_no_pulse", n_pulse - p0, 0);
    chk("t3_held_zero", {29'd0, key_held}, 32'h0);
    send_frame(8'h1D, 0, 0);
    chk("t3_good_pulse", n_pulse - p0, 1);
    chk("t3_good_held", {29'd0, key_held}, 32'h4);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1D, 0, 0);

    // Timeout drops the pending E0 prefix.
    p0 = n_pulse; e0 = n_err;
    send_frame(8'hE0, 0, 0);
    send_partial(8'h55, 5);
    chk("t4_tmo_err", n_err - e0, 1);
    send_frame(8'h72, 0, 0);
    chk("t4_prefix_dropped", n_pulse - p0, 0);
    chk("t4_held_after_72", {29'd0, key_held}, 32'h0);
    send_frame(8'h1B, 0, 0);
    chk("t4_down_pulse", n_pulse - p0, 1);
    chk("t4_down_held", {29'd0, key_held}, 32'h2);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1B, 0, 0);

    // W and arrow-up share the up bit.
    p0 = n_pulse;
    send_frame(8'h1D, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    chk("t5_alias_pulse", n_pulse - p0, 1);
    chk("t5_alias_held", {29'd0, key_held}, 32'h4);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    chk("t5_alias_break", {29'd0, key_held}, 32'h0);

    // Reset in the middle of a frame while a key is held.
    send_frame(8'h5A, 0, 0);
    chk("t6_held_before", {29'd0, key_held}, 32'h1);
    for (int i = 0; i < 6; i++) begin
      ps2_fall(frame_bit(8'h29, i, 0, 0), c0);
      ps2_rise();
    end
    ps2_data = 1'b1;
    idle(1);
    rst = 1'b0;
    kbd_q.delete(); held_q.delete(); err_q.delete();
    m_held = 3'b000; m_ext = 0; m_brk = 0;
    #1;
    chk("t6_reset_held", {29'd0, key_held}, 32'h0);
    chk("t6_reset_kbd", {29'd0, keyboard_out}, 32'h0);
    chk("t6_reset_err", {31'd0, frame_error}, 32'h0);
    idle(5);
    rst = 1'b1;
    idle(5);
    p0 = n_pulse;
    send_frame(8'h29, 0, 0);
    chk("t6_space_pulse", n_pulse - p0, 1);
    chk("t6_space_held", {29'd0, key_held}, 32'h1);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h29, 0, 0);

    // Randomised frame mix.
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3 && n_tmo < 2) begin
        n_tmo++;
        send_partial(8'($urandom), $urandom_range(1, 10));
      end else if (r < 8) begin
        send_start_err();
      end else if (r < 14) begin
        if ($urandom_range(0, 1) == 1) send_frame(pool[$urandom_range(0, 9)], 1, 0);
        else                           send_frame(pool[$urandom_range(0, 9)], 0, 1);
      end else if (r < 20) begin
        send_frame(8'($urandom), 0, 0);
      end else begin
        send_frame(pool[$urandom_range(0, 9)], 0, 0);
      end
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
